// File: rtl/hmmm_memory.sv
// ---------------------------------------------------------------------------
// hmmm_memory
//
// Unified program/data memory for the hmmm processor, plus program bring-up.
// After reset it accepts a program image over a valid/ready load stream
// while holding the processor in reset. After the last word it waits two
// cycles so the processor's two-phase flops clear, then releases it.
//
// Ports
//   ph1        : clock; all state changes on its rising edge
//   reset      : synchronous, active-high
//   Adr        : processor address
//   MemWrite   : processor store strobe (low byte only)
//   MemData1   : high field of mem[Adr], combinational, always driven
//   MemData2   : low byte, bidirectional; driven by this block on reads
//                while the processor runs, driven by the processor on stores
//   ld_valid   : load word offered
//   ld_ready   : load word accepted this cycle
//   ld_data    : load word
//   ld_last    : current load word is the last of the image
//   cpu_reset  : reset to the processor (registered)
//   run        : processor released (registered)
//   ld_err     : sticky flag, image overflowed the memory (registered)
//   wr_count   : saturating count of processor stores since reset
// ---------------------------------------------------------------------------
module hmmm_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 15
) (
    input  logic                  ph1,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Adr,
    input  logic                  MemWrite,
    output logic [WORD_WIDTH-9:0] MemData1,
    inout  wire  [7:0]            MemData2,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [WORD_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  cpu_reset,
    output logic                  run,
    output logic                  ld_err,
    output logic [7:0]            wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_ld_ptr;
    logic [ADDR_WIDTH-1:0] w_ld_ptr_next;
    logic                  r_flush_cnt;
    logic                  w_flush_cnt_next;
    logic                  r_ld_err;
    logic                  w_ld_err_next;
    logic [7:0]            r_wr_count;
    logic [7:0]            w_wr_count_next;
    logic                  r_cpu_reset;
    logic                  r_run;

    logic                  w_ld_xfer;
    logic                  w_store;
    logic [WORD_WIDTH-1:0] w_rd_word;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];

    // -----------------------------------------------------------------------
    // Next-state and load/store decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_ld_ptr_next    = r_ld_ptr;
        w_flush_cnt_next = r_flush_cnt;
        w_ld_err_next    = r_ld_err;
        w_wr_count_next  = r_wr_count;
        ld_ready         = 1'b0;
        w_ld_xfer        = 1'b0;
        w_store          = 1'b0;

        case (r_state)
            S_LOAD: begin
                ld_ready  = 1'b1;
                w_ld_xfer = ld_valid;
                if (ld_valid) begin
                    w_ld_ptr_next = r_ld_ptr + 1'b1;
                    // Running off the top of memory without seeing the last
                    // word means the image is too big; keep loading anyway.
                    if ((&r_ld_ptr) && !ld_last) begin
                        w_ld_err_next = 1'b1;
                    end
                    if (ld_last) begin
                        w_state_next     = S_FLUSH;
                        w_flush_cnt_next = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                // Two cycles of held reset so both processor phases clear.
                if (r_flush_cnt) begin
                    w_state_next = S_RUN;
                end else begin
                    w_flush_cnt_next = 1'b1;
                end
            end
            S_RUN: begin
                w_store = MemWrite;
                if (MemWrite && (r_wr_count != 8'hFF)) begin
                    w_wr_count_next = r_wr_count + 8'd1;
                end
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase

        // Reset cycle: no handshake and no memory writes of any kind.
        if (reset) begin
            ld_ready  = 1'b0;
            w_ld_xfer = 1'b0;
            w_store   = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_ld_ptr    <= '0;
            r_flush_cnt <= 1'b0;
            r_ld_err    <= 1'b0;
            r_wr_count  <= 8'd0;
            r_cpu_reset <= 1'b1;
            r_run       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ld_ptr    <= w_ld_ptr_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_ld_err    <= w_ld_err_next;
            r_wr_count  <= w_wr_count_next;
            // Registered from the next state so release coincides with the
            // edge that enters RUN.
            r_cpu_reset <= (w_state_next != S_RUN);
            r_run       <= (w_state_next == S_RUN);
        end
    end

    // -----------------------------------------------------------------------
    // Memory array: not cleared by reset. Loads write the whole word, stores
    // only the low byte. The two never coincide (LOAD vs RUN).
    // -----------------------------------------------------------------------
    always_ff @(posedge ph1) begin
        if (w_ld_xfer) begin
            r_mem[r_ld_ptr] <= ld_data;
        end else if (w_store) begin
            r_mem[Adr][7:0] <= MemData2;
        end
    end

    // Combinational read; the low byte is released the moment MemWrite rises
    // so the processor can drive the shared bus in a store cycle.
    assign w_rd_word = r_mem[Adr];
    assign MemData1  = w_rd_word[WORD_WIDTH-1:8];
    assign MemData2  = (r_run && !MemWrite) ? w_rd_word[7:0] : 8'bz;

    assign cpu_reset = r_cpu_reset;
    assign run       = r_run;
    assign ld_err    = r_ld_err;
    assign wr_count  = r_wr_count;

endmodule
